// File: rtl/spi_jugada_tx.sv
// SPI mode-0 master sending one 8-bit move frame {3'b101, 1'b0, p, jugada}, MSB first.
// Optional macro SPI_JUGADA_PARITY_EN puts the even parity of jugada in frame bit 3 (0 otherwise).
module spi_jugada_tx #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] jugada_in,
    input  logic       enviar,
    output logic       listo,
    output logic       done,
    output logic       sck,
    output logic       mosi,
    output logic       ss_n
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

    state_t          state;
    logic [7:0]      shreg;
    logic [2:0]      bit_cnt;
    logic [DW-1:0]   div_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [7:0]      frame;

    always_comb begin
        frame = {3'b101, 2'b00, jugada_in};
`ifdef SPI_JUGADA_PARITY_EN
        frame[3] = ^jugada_in;
`else
        frame[3] = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            gap_cnt <= '0;
            listo   <= 1'b1;
            done    <= 1'b0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            ss_n    <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enviar) begin
                        shreg   <= frame;
                        bit_cnt <= '0;
                        div_cnt <= DIV_LOAD;
                        listo   <= 1'b0;
                        ss_n    <= 1'b0;
                        sck     <= 1'b0;
                        mosi    <= frame[7];
                        state   <= SETUP;
                    end
                end
                SETUP, LOW: begin
                    if (div_cnt == '0) begin
                        div_cnt <= DIV_LOAD;
                        sck     <= 1'b1;
                        state   <= HIGH;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                HIGH: begin
                    if (div_cnt == '0) begin
                        div_cnt <= DIV_LOAD;
                        sck     <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            state <= HOLD;
                        end else begin
                            // next bit goes out on the falling edge, half a period before the rise
                            shreg   <= {shreg[6:0], 1'b0};
                            mosi    <= shreg[6];
                            bit_cnt <= bit_cnt + 3'd1;
                            state   <= LOW;
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (div_cnt == '0) begin
                        ss_n    <= 1'b1;
                        mosi    <= 1'b0;
                        done    <= 1'b1;
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        listo <= 1'b1;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
